lfsr_seq_checker: RTL and testbench
===================================

Name: lfsr_seq_checker

Overview:
- Receive-side checker for the 24-bit noise LFSR bitstream.
- Consumes the serial sequence one bit per valid strobe and self-synchronises a shadow LFSR to it.
- Once synchronised, predicts each following bit and declares lock or loss of lock.
- Keeps a saturating mismatch count, so bench and board debug can confirm the noise source runs the right polynomial and has not stalled.

Parameters:
- LOCK_COUNT, 48: consecutive correct predictions needed after fill to declare lock (1..255).
- WINDOW, 64: number of valid bits per error-monitoring window while locked (2..255).
- ERR_LIMIT, 4: mismatches within one window that force loss of lock (1..WINDOW).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- bit_in  in  1  serial sequence bit; each new generator LSB, i.e. its feedback bit.
- bit_valid  in  1  qualifies bit_in; bits with bit_valid low are ignored entirely.
- clear_stats  in  1  synchronous clear of err_count.
- locked  out  1  high while state is LOCKED.
- sync_state  out  2  0=FILL, 1=VERIFY, 2=LOCKED; 3 is unused.
- err_pulse  out  1  one-cycle pulse per mismatch detected in LOCKED.
- err_count  out  16  saturating total of mismatches detected in LOCKED.

Behaviour:
- One clock domain; reset is synchronous and active-low. While reset_n is low at a clk edge:
  - state=FILL; shadow register, fill counter, match counter, window counter and window error counter all 0;
  - locked=0, err_pulse=0, err_count=0.
  - Reset mid-operation behaves identically; all outputs read 0 the cycle after the edge.
- Shadow register s[23:0]: newest bit in s[0]. Prediction p = s[23]^s[22]^s[20]^s[19], the same taps as the generator.
- All outputs are registered. A bit_valid at edge N is reflected on outputs after edge N (latency 1).
- FILL:
  - Each valid bit does s <= {s[22:0], bit_in}, fill counter +1.
  - After the 24th valid bit: if the resulting s is 0, restart FILL (counter 0), because all-zero is the illegal lock-up state. Otherwise go to VERIFY with match counter 0.
- VERIFY:
  - Each valid bit: s <= {s[22:0], bit_in}.
  - If bit_in==p, match counter +1; reaching LOCK_COUNT moves to LOCKED, with window counter 0 and window error counter 0.
  - If bit_in!=p, return to FILL with fill counter 0. s keeps shifting, but FILL refills all 24 bits anyway.
  - No err_pulse and no err_count change in VERIFY.
- LOCKED:
  - Flywheel operation: s <= {s[22:0], p}. The predicted bit is shifted in, so corrupted input bits do not corrupt the shadow.
  - On mismatch: err_pulse=1 for one cycle, err_count +1 (saturates at 16'hFFFF), window error counter +1.
  - If the window error counter reaches ERR_LIMIT on this bit, go to FILL (fill counter 0), locked drops after this edge, and window counters clear.
  - Window counter +1 per valid bit. When it reaches WINDOW, both window counters reset to 0. If the limit hit and the window end coincide on one bit, loss of lock wins.
- clear_stats=1 zeroes err_count at that edge. If a mismatch lands on the same edge, clear wins (err_count=0), but err_pulse still fires. clear_stats does not affect state or counters.
- err_pulse is 0 on any cycle without a LOCKED mismatch, including cycles where bit_valid is low.
- bit_valid may be held high continuously or gapped arbitrarily; behaviour depends only on the count and order of valid bits.

Test Plan:
- Lock: reference model seeded 24'h000001, continuous bit_valid → sync_state=1 after valid bit 24, locked=1 after valid bit 72, err_count=0.
- Gapped input: same stream with bit_valid low on every other cycle → locked rises after valid bit 72 (cycle 143), never earlier.
- Single error: invert stream bit 100 once locked → exactly one err_pulse, err_count=1, locked stays 1, and bits 101..200 produce no further pulses (flywheel).
- Loss of lock: invert 4 bits within one 64-bit window while locked → locked=0 and sync_state=0 after the 4th, err_count=4. Clean bits after that relock after 72 more valid bits.
- Illegal stream and early error: constant 0 input → never leaves FILL, locked=0 forever. Flip a bit at position 30 (in VERIFY) → returns to FILL, err_count stays 0.
- Clear, saturation and reset: clear_stats coincident with a mismatch → err_count=0 with err_pulse=1. Preload via forced errors to 16'hFFFF → stays 16'hFFFF. reset_n low one cycle while locked → all outputs 0 next cycle, state FILL.

Source files
------------

// File: rtl/lfsr_seq_checker.sv
// Receive-side checker that self-synchronises a shadow 24-bit LFSR to a serial stream and tracks lock.
// Latency 1 cycle from a valid bit to all outputs; always accepts input (no backpressure).
module lfsr_seq_checker #(
   parameter int LOCK_COUNT = 48,
   parameter int WINDOW     = 64,
   parameter int ERR_LIMIT  = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        bit_in,
   input  logic        bit_valid,
   input  logic        clear_stats,
   output logic        locked,
   output logic [1:0]  sync_state,
   output logic        err_pulse,
   output logic [15:0] err_count
);

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
   localparam logic [7:0] WIN_LAST  = 8'(WINDOW - 1);
   localparam logic [7:0] ERR_LAST  = 8'(ERR_LIMIT - 1);

   state_t      state;
   logic [23:0] shadow;
   logic [4:0]  fill_cnt;
   logic [7:0]  match_cnt;
   logic [7:0]  win_cnt;
   logic [7:0]  win_err;
   logic        predict;
   logic        mismatch;
   logic [23:0] shift_in;

   assign predict    = shadow[23] ^ shadow[22] ^ shadow[20] ^ shadow[19];
   assign mismatch   = bit_in ^ predict;
   assign shift_in   = {shadow[22:0], bit_in};
   assign sync_state = state;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= FILL;
         shadow    <= '0;
         fill_cnt  <= '0;
         match_cnt <= '0;
         win_cnt   <= '0;
         win_err   <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_count <= '0;
      end else begin
         err_pulse <= 1'b0;

         // Clear has priority over a same-edge increment.
         if (clear_stats)
            err_count <= '0;
         else if (bit_valid && state == LOCKED && mismatch && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;

         if (bit_valid) begin
            unique case (state)
               FILL: begin
                  shadow <= shift_in;
                  if (fill_cnt == 5'd23) begin
                     fill_cnt <= '0;
                     // An all-zero shadow is the LFSR lock-up state; keep filling.
                     if (shift_in != '0) begin
                        state     <= VERIFY;
                        match_cnt <= '0;
                     end
                  end else begin
                     fill_cnt <= fill_cnt + 5'd1;
                  end
               end
               VERIFY: begin
                  shadow <= shift_in;
                  if (mismatch) begin
                     state    <= FILL;
                     fill_cnt <= '0;
                  end else if (match_cnt == LOCK_LAST) begin
                     state   <= LOCKED;
                     locked  <= 1'b1;
                     win_cnt <= '0;
                     win_err <= '0;
                  end else begin
                     match_cnt <= match_cnt + 8'd1;
                  end
               end
               LOCKED: begin
                  // Flywheel: shift the prediction so bad input bits never corrupt the shadow.
                  shadow    <= {shadow[22:0], predict};
                  err_pulse <= mismatch;
                  if (mismatch && win_err == ERR_LAST) begin
                     state    <= FILL;
                     locked   <= 1'b0;
                     fill_cnt <= '0;
                     win_cnt  <= '0;
                     win_err  <= '0;
                  end else if (win_cnt == WIN_LAST) begin
                     win_cnt <= '0;
                     win_err <= '0;
                  end else begin
                     win_cnt <= win_cnt + 8'd1;
                     win_err <= win_err + {7'd0, mismatch};
                  end
               end
               default: begin
                  state    <= FILL;
                  locked   <= 1'b0;
                  fill_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker: reference LFSR stream, expected outputs queued per driven cycle.
module tb_lfsr_seq_checker;

   logic        clk = 1'b0;
   logic        reset_n, bit_in, bit_valid, clear_stats;
   logic        locked, err_pulse;
   logic [1:0]  sync_state;
   logic [15:0] err_count;
   logic        b_bit, b_valid, b_clr;
   logic        b_locked, b_pulse;
   logic [1:0]  b_state;
   logic [15:0] b_count;

   int          n_vec  = 0;
   int          n_fail = 0;
   logic [19:0] exp_q[$];
   logic [19:0] exp_qb[$];
   logic [23:0] g;

   always #5 clk = ~clk;

   lfsr_seq_checker dut (
      .clk(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
      .clear_stats(clear_stats), .locked(locked), .sync_state(sync_state),
      .err_pulse(err_pulse), .err_count(err_count)
   );

   lfsr_seq_checker #(.LOCK_COUNT(1), .WINDOW(255), .ERR_LIMIT(255)) dut_sat (
      .clk(clk), .reset_n(reset_n), .bit_in(b_bit), .bit_valid(b_valid),
      .clear_stats(b_clr), .locked(b_locked), .sync_state(b_state),
      .err_pulse(b_pulse), .err_count(b_count)
   );

   task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic gen(output logic b);
      b = g[23] ^ g[22] ^ g[20] ^ g[19];
      g = {g[22:0], b};
   endtask

   function automatic logic [1:0] acq(input int j);
      if (j < 24) return 2'd0;
      if (j < 72) return 2'd1;
      return 2'd2;
   endfunction

   task automatic send(input string tag, input logic b, input logic v, input logic clr,
                       input logic [1:0] st, input logic pulse, input logic [15:0] cnt);
      logic [19:0] e;
      bit_in      = b;
      bit_valid   = v;
      clear_stats = clr;
      exp_q.push_back({(st == 2'd2), st, pulse, cnt});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check(tag, {locked, sync_state, err_pulse, err_count}, e);
   endtask

   task automatic sendb(input logic b, input logic lk, input logic pulse, input logic [15:0] cnt);
      logic [19:0] e;
      b_bit   = b;
      b_valid = 1'b1;
      b_clr   = 1'b0;
      exp_qb.push_back({2'b00, lk, pulse, cnt});
      @(posedge clk);
      #1;
      e = exp_qb.pop_front();
      check("saturate", {2'b00, b_locked, b_pulse, b_count}, e);
   endtask

   initial begin
      logic        b, err, clr, rb;
      logic [15:0] ecnt;
      int          be;

      reset_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; clear_stats = 1'b0;
      b_bit = 1'b0; b_valid = 1'b0; b_clr = 1'b0;

      // Reset state, with valid/clear asserted to confirm they are ignored.
      send("reset", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 16'd0);
      send("reset", 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 16'd0);
      reset_n = 1'b1;

      // Continuous lock from seed 1.
      g = 24'h000001;
      for (int k = 1; k <= 72; k++) begin
         gen(b);
         send("lock", b, 1'b1, 1'b0, acq(k), 1'b0, 16'd0);
      end

      // Single inverted bit while locked; flywheel must keep the shadow clean.
      for (int k = 73; k <= 200; k++) begin
         gen(b);
         err = (k == 100);
         send("single_err", b ^ err, 1'b1, 1'b0, 2'd2, err, (k >= 100) ? 16'd1 : 16'd0);
      end

      // Four errors inside the window 201..264 force loss of lock.
      ecnt = 16'd0;
      for (int k = 201; k <= 240; k++) begin
         gen(b);
         err = (k == 210) || (k == 220) || (k == 230) || (k == 240);
         clr = (k == 201);
         if (err) ecnt++;
         send("loss", b ^ err, 1'b1, clr, (k == 240) ? 2'd0 : 2'd2, err, ecnt);
      end
      for (int k = 241; k <= 312; k++) begin
         gen(b);
         send("relock", b, 1'b1, 1'b0, acq(k - 240), 1'b0, 16'd4);
      end

      // Three errors at the end of one window plus one at the start of the next stay locked;
      // the fourth coincides with clear_stats.
      ecnt = 16'd4;
      for (int k = 313; k <= 400; k++) begin
         gen(b);
         err = (k == 374) || (k == 375) || (k == 376) || (k == 377) || (k == 390);
         clr = (k == 377);
         if (err) ecnt++;
         if (clr) ecnt = 16'd0;
         send("window", b ^ err, 1'b1, clr, 2'd2, err, ecnt);
      end

      // One-cycle reset while locked with a nonzero count.
      reset_n = 1'b0;
      send("reset_locked", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 16'd0);
      reset_n = 1'b1;

      // Gapped stream: valid on every other cycle, garbage on the idle cycles.
      g = 24'h000001;
      for (int k = 1; k <= 72; k++) begin
         gen(b);
         send("gap_valid", b, 1'b1, 1'b0, acq(k), 1'b0, 16'd0);
         rb = 1'($urandom_range(0, 1));
         send("gap_idle", rb, 1'b0, 1'b0, acq(k), 1'b0, 16'd0);
      end

      // Constant-zero stream never leaves FILL.
      reset_n = 1'b0;
      send("reset2", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0);
      reset_n = 1'b1;
      for (int k = 1; k <= 100; k++)
         send("zeros", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 16'd0);

      // Error during VERIFY at bit 30 returns to FILL with no error accounting, then relocks.
      reset_n = 1'b0;
      send("reset3", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0);
      reset_n = 1'b1;
      g = 24'h000001;
      for (int k = 1; k <= 102; k++) begin
         gen(b);
         err = (k == 30);
         send("verify_err", b ^ err, 1'b1, 1'b0,
              (k < 30) ? acq(k) : ((k == 30) ? 2'd0 : acq(k - 30)), 1'b0, 16'd0);
      end
      bit_valid = 1'b0;

      // Saturation on the wide-window instance: 254 errors per 255-bit window keeps lock.
      g = 24'h000001;
      for (int k = 1; k <= 25; k++) begin
         gen(b);
         sendb(b, (k == 25), 1'b0, 16'd0);
      end
      be = 0;
      for (int n = 0; be < 65540; n++) begin
         gen(b);
         err = ((n % 255) != 0);
         if (err) be++;
         sendb(b ^ err, 1'b1, err, (be > 65535) ? 16'hFFFF : 16'(be));
      end
      b_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
